memory_operand_fetch: RTL and testbench

MEMORY_OPERAND_FETCH -- requirements
Module: memory_operand_fetch

---
 rtl/memory_operand_fetch.sv | 179 +++++++++++++++++
 tb/tb_memory_operand_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_operand_fetch.sv
// Operand fetch stage: captures an address-calculated instruction, issues up to
// two memory reads for source operands, and presents the resolved operands downstream.
module memory_operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        validIn,
    input  logic [7:0]  opcodeIn,
    input  logic [3:0]  destRegIn,
    input  logic        destRegValidIn,
    input  logic [63:0] operand1ValIn,
    input  logic [63:0] operand2ValIn,
    input  logic        isMemoryAccessSrc1In,
    input  logic        isMemoryAccessSrc2In,
    input  logic        isMemoryAccessDestIn,
    input  logic [63:0] memoryAddressSrc1In,
    input  logic [63:0] memoryAddressSrc2In,
    input  logic [63:0] memoryAddressDestIn,
    input  logic        stallIn,
    input  logic        flushIn,
    input  logic        memReqReadyIn,
    input  logic        memRespValidIn,
    input  logic [63:0] memRespDataIn,
    output logic        busyOut,
    output logic        memReqValidOut,
    output logic [63:0] memReqAddrOut,
    output logic        validOut,
    output logic [7:0]  opcodeOut,
    output logic [3:0]  destRegOut,
    output logic        destRegValidOut,
    output logic        isMemoryAccessDestOut,
    output logic [63:0] memoryAddressDestOut,
    output logic [63:0] operand1ValOut,
    output logic [63:0] operand2ValOut
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        DONE  = 3'd5,
        DRAIN = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [3:0]  dest_reg_q, dest_reg_d;
    logic        dest_reg_valid_q, dest_reg_valid_d;
    logic        src1_mem_q, src1_mem_d;
    logic        src2_mem_q, src2_mem_d;
    logic        dest_mem_q, dest_mem_d;
    logic [63:0] addr1_q, addr1_d;
    logic [63:0] addr2_q, addr2_d;
    logic [63:0] addr_dest_q, addr_dest_d;
    logic [63:0] op1_q, op1_d;
    logic [63:0] op2_q, op2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            opcode_q         <= '0;
            dest_reg_q       <= '0;
            dest_reg_valid_q <= 1'b0;
            src1_mem_q       <= 1'b0;
            src2_mem_q       <= 1'b0;
            dest_mem_q       <= 1'b0;
            addr1_q          <= '0;
            addr2_q          <= '0;
            addr_dest_q      <= '0;
            op1_q            <= '0;
            op2_q            <= '0;
        end else begin
            state_q          <= state_d;
            opcode_q         <= opcode_d;
            dest_reg_q       <= dest_reg_d;
            dest_reg_valid_q <= dest_reg_valid_d;
            src1_mem_q       <= src1_mem_d;
            src2_mem_q       <= src2_mem_d;
            dest_mem_q       <= dest_mem_d;
            addr1_q          <= addr1_d;
            addr2_q          <= addr2_d;
            addr_dest_q      <= addr_dest_d;
            op1_q            <= op1_d;
            op2_q            <= op2_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        opcode_d         = opcode_q;
        dest_reg_d       = dest_reg_q;
        dest_reg_valid_d = dest_reg_valid_q;
        src1_mem_d       = src1_mem_q;
        src2_mem_d       = src2_mem_q;
        dest_mem_d       = dest_mem_q;
        addr1_d          = addr1_q;
        addr2_d          = addr2_q;
        addr_dest_d      = addr_dest_q;
        op1_d            = op1_q;
        op2_d            = op2_q;

        case (state_q)
            IDLE: begin
                if (validIn && !flushIn) begin
                    opcode_d         = opcodeIn;
                    dest_reg_d       = destRegIn;
                    dest_reg_valid_d = destRegValidIn;
                    src1_mem_d       = isMemoryAccessSrc1In;
                    src2_mem_d       = isMemoryAccessSrc2In;
                    dest_mem_d       = isMemoryAccessDestIn;
                    addr1_d          = memoryAddressSrc1In;
                    addr2_d          = memoryAddressSrc2In;
                    addr_dest_d      = memoryAddressDestIn;
                    op1_d            = operand1ValIn;
                    op2_d            = operand2ValIn;
                    if (isMemoryAccessSrc1In)      state_d = REQ1;
                    else if (isMemoryAccessSrc2In) state_d = REQ2;
                    else                           state_d = DONE;
                end
            end
            REQ1: begin
                if (flushIn)            state_d = IDLE;
                else if (memReqReadyIn) state_d = WAIT1;
            end
            WAIT1: begin
                // A flush with a read outstanding must still absorb its response.
                if (flushIn) begin
                    state_d = DRAIN;
                end else if (memRespValidIn) begin
                    op1_d   = memRespDataIn;
                    state_d = src2_mem_q ? REQ2 : DONE;
                end
            end
            REQ2: begin
                if (flushIn)            state_d = IDLE;
                else if (memReqReadyIn) state_d = WAIT2;
            end
            WAIT2: begin
                if (flushIn) begin
                    state_d = DRAIN;
                end else if (memRespValidIn) begin
                    op2_d   = memRespDataIn;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flushIn || !stallIn) state_d = IDLE;
            end
            DRAIN: begin
                if (memRespValidIn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busyOut        = (state_q != IDLE);
        validOut       = (state_q == DONE);
        memReqValidOut = 1'b0;
        memReqAddrOut  = '0;
        if (state_q == REQ1) begin
            memReqValidOut = 1'b1;
            memReqAddrOut  = addr1_q;
        end else if (state_q == REQ2) begin
            memReqValidOut = 1'b1;
            memReqAddrOut  = addr2_q;
        end
    end

    assign opcodeOut             = opcode_q;
    assign destRegOut            = dest_reg_q;
    assign destRegValidOut       = dest_reg_valid_q;
    assign isMemoryAccessDestOut = dest_mem_q;
    assign memoryAddressDestOut  = addr_dest_q;
    assign operand1ValOut        = op1_q;
    assign operand2ValOut        = op2_q;

endmodule

// File: tb/tb_memory_operand_fetch.sv
// Directed bench for memory_operand_fetch: a table of register-only instructions
// followed by hand-written sequences for loads, stalls, flush and async reset.
module tb_memory_operand_fetch;

    logic        clk;
    logic        reset;
    logic        validIn;
    logic [7:0]  opcodeIn;
    logic [3:0]  destRegIn;
    logic        destRegValidIn;
    logic [63:0] operand1ValIn;
    logic [63:0] operand2ValIn;
    logic        isMemoryAccessSrc1In;
    logic        isMemoryAccessSrc2In;
    logic        isMemoryAccessDestIn;
    logic [63:0] memoryAddressSrc1In;
    logic [63:0] memoryAddressSrc2In;
    logic [63:0] memoryAddressDestIn;
    logic        stallIn;
    logic        flushIn;
    logic        memReqReadyIn;
    logic        memRespValidIn;
    logic [63:0] memRespDataIn;
    logic        busyOut;
    logic        memReqValidOut;
    logic [63:0] memReqAddrOut;
    logic        validOut;
    logic [7:0]  opcodeOut;
    logic [3:0]  destRegOut;
    logic        destRegValidOut;
    logic        isMemoryAccessDestOut;
    logic [63:0] memoryAddressDestOut;
    logic [63:0] operand1ValOut;
    logic [63:0] operand2ValOut;

    int unsigned n_vec;
    int unsigned n_bad;

    memory_operand_fetch dut (
        .clk                   (clk),
        .reset                 (reset),
        .validIn               (validIn),
        .opcodeIn              (opcodeIn),
        .destRegIn             (destRegIn),
        .destRegValidIn        (destRegValidIn),
        .operand1ValIn         (operand1ValIn),
        .operand2ValIn         (operand2ValIn),
        .isMemoryAccessSrc1In  (isMemoryAccessSrc1In),
        .isMemoryAccessSrc2In  (isMemoryAccessSrc2In),
        .isMemoryAccessDestIn  (isMemoryAccessDestIn),
        .memoryAddressSrc1In   (memoryAddressSrc1In),
        .memoryAddressSrc2In   (memoryAddressSrc2In),
        .memoryAddressDestIn   (memoryAddressDestIn),
        .stallIn               (stallIn),
        .flushIn               (flushIn),
        .memReqReadyIn         (memReqReadyIn),
        .memRespValidIn        (memRespValidIn),
        .memRespDataIn         (memRespDataIn),
        .busyOut               (busyOut),
        .memReqValidOut        (memReqValidOut),
        .memReqAddrOut         (memReqAddrOut),
        .validOut              (validOut),
        .opcodeOut             (opcodeOut),
        .destRegOut            (destRegOut),
        .destRegValidOut       (destRegValidOut),
        .isMemoryAccessDestOut (isMemoryAccessDestOut),
        .memoryAddressDestOut  (memoryAddressDestOut),
        .operand1ValOut        (operand1ValOut),
        .operand2ValOut        (operand2ValOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  opcode;
        logic [3:0]  dest;
        logic        dest_valid;
        logic        dest_mem;
        logic [63:0] dest_addr;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] exp_op1;
        logic [63:0] exp_op2;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        validIn              = 1'b0;
        opcodeIn             = '0;
        destRegIn            = '0;
        destRegValidIn       = 1'b0;
        operand1ValIn        = '0;
        operand2ValIn        = '0;
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        isMemoryAccessDestIn = 1'b0;
        memoryAddressSrc1In  = '0;
        memoryAddressSrc2In  = '0;
        memoryAddressDestIn  = '0;
        stallIn              = 1'b0;
        flushIn              = 1'b0;
        memReqReadyIn        = 1'b0;
        memRespValidIn       = 1'b0;
        memRespDataIn        = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},   64'(busyOut), 64'd0);
        check({tag, ".valid"},  64'(validOut), 64'd0);
        check({tag, ".reqv"},   64'(memReqValidOut), 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{8'h01, 4'h3, 1'b1, 1'b0, 64'h0, 64'h5, 64'h7, 64'h5, 64'h7};
        vecs[1] = '{8'hFF, 4'hF, 1'b0, 1'b1, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[2] = '{8'h80, 4'h0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h8000_0000_0000_0001,
                    64'h0, 64'h8000_0000_0000_0001};
        vecs[3] = '{8'h5A, 4'hA, 1'b1, 1'b1, 64'hCAFE_0000, 64'h1234_5678_9ABC_DEF0,
                    64'h0FED_CBA9_8765_4321, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};

        clear_inputs();
        reset = 1'b1;
        #1;
        check_idle("reset");
        check("reset.op1", operand1ValOut, 64'h0);
        check("reset.addr", memReqAddrOut, 64'h0);
        step();
        step();
        reset = 1'b0;
        step();
        check_idle("post_reset");

        // Register-only instructions: DONE one cycle after capture, then IDLE.
        for (int i = 0; i < 4; i++) begin
            validIn              = 1'b1;
            opcodeIn             = vecs[i].opcode;
            destRegIn            = vecs[i].dest;
            destRegValidIn       = vecs[i].dest_valid;
            isMemoryAccessDestIn = vecs[i].dest_mem;
            memoryAddressDestIn  = vecs[i].dest_addr;
            operand1ValIn        = vecs[i].op1;
            operand2ValIn        = vecs[i].op2;
            step();
            validIn = 1'b0;
            check($sformatf("reg%0d.valid", i), 64'(validOut), 64'd1);
            check($sformatf("reg%0d.busy", i), 64'(busyOut), 64'd1);
            check($sformatf("reg%0d.reqv", i), 64'(memReqValidOut), 64'd0);
            check($sformatf("reg%0d.op1", i), operand1ValOut, vecs[i].exp_op1);
            check($sformatf("reg%0d.op2", i), operand2ValOut, vecs[i].exp_op2);
            check($sformatf("reg%0d.opc", i), 64'(opcodeOut), 64'(vecs[i].opcode));
            check($sformatf("reg%0d.dst", i), 64'(destRegOut), 64'(vecs[i].dest));
            check($sformatf("reg%0d.dstv", i), 64'(destRegValidOut), 64'(vecs[i].dest_valid));
            check($sformatf("reg%0d.dmem", i), 64'(isMemoryAccessDestOut), 64'(vecs[i].dest_mem));
            check($sformatf("reg%0d.daddr", i), memoryAddressDestOut, vecs[i].dest_addr);
            step();
            check_idle($sformatf("reg%0d.after", i));
        end

        // Src1 load, zero-wait memory.
        clear_inputs();
        validIn = 1'b1;
        isMemoryAccessSrc1In = 1'b1;
        memoryAddressSrc1In  = 64'h1000;
        operand1ValIn        = 64'h11;
        operand2ValIn        = 64'h22;
        memReqReadyIn        = 1'b1;
        step();
        validIn = 1'b0;
        check("ld1.reqv", 64'(memReqValidOut), 64'd1);
        check("ld1.addr", memReqAddrOut, 64'h1000);
        check("ld1.valid_req", 64'(validOut), 64'd0);
        step();
        check("ld1.wait_reqv", 64'(memReqValidOut), 64'd0);
        check("ld1.wait_addr", memReqAddrOut, 64'h0);
        check("ld1.wait_busy", 64'(busyOut), 64'd1);
        memRespValidIn = 1'b1;
        memRespDataIn  = 64'hDEAD_BEEF;
        step();
        memRespValidIn = 1'b0;
        check("ld1.valid", 64'(validOut), 64'd1);
        check("ld1.op1", operand1ValOut, 64'hDEAD_BEEF);
        check("ld1.op2", operand2ValOut, 64'h22);
        step();
        check_idle("ld1.after");

        // Two loads, ready low for 3 cycles; a stray response in REQ2 is ignored.
        clear_inputs();
        validIn = 1'b1;
        isMemoryAccessSrc1In = 1'b1;
        isMemoryAccessSrc2In = 1'b1;
        memoryAddressSrc1In  = 64'h2000;
        memoryAddressSrc2In  = 64'h3000;
        operand1ValIn        = 64'h1;
        operand2ValIn        = 64'h2;
        step();
        validIn = 1'b0;
        memoryAddressSrc1In = 64'h9999;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ld2.hold%0d.reqv", c), 64'(memReqValidOut), 64'd1);
            check($sformatf("ld2.hold%0d.addr", c), memReqAddrOut, 64'h2000);
            if (c < 2) step();
        end
        memReqReadyIn = 1'b1;
        step();
        check("ld2.w1_reqv", 64'(memReqValidOut), 64'd0);
        memRespValidIn = 1'b1;
        memRespDataIn  = 64'hAAAA_0001;
        step();
        check("ld2.r2_reqv", 64'(memReqValidOut), 64'd1);
        check("ld2.r2_addr", memReqAddrOut, 64'h3000);
        memRespDataIn = 64'h5555_5555;
        step();
        check("ld2.w2_reqv", 64'(memReqValidOut), 64'd0);
        check("ld2.w2_op2", operand2ValOut, 64'h2);
        memRespDataIn = 64'hBBBB_0002;
        step();
        memRespValidIn = 1'b0;
        check("ld2.valid", 64'(validOut), 64'd1);
        check("ld2.op1", operand1ValOut, 64'hAAAA_0001);
        check("ld2.op2", operand2ValOut, 64'hBBBB_0002);
        step();
        check_idle("ld2.after");

        // Downstream stall held in DONE.
        clear_inputs();
        validIn = 1'b1;
        opcodeIn = 8'h42;
        operand1ValIn = 64'hA1;
        operand2ValIn = 64'hB2;
        stallIn = 1'b1;
        step();
        validIn = 1'b0;
        operand1ValIn = 64'hFF;
        opcodeIn = 8'h00;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall%0d.valid", c), 64'(validOut), 64'd1);
            check($sformatf("stall%0d.busy", c), 64'(busyOut), 64'd1);
            check($sformatf("stall%0d.op1", c), operand1ValOut, 64'hA1);
            check($sformatf("stall%0d.opc", c), 64'(opcodeOut), 64'h42);
            if (c < 3) step();
        end
        stallIn = 1'b0;
        step();
        check_idle("stall.after");

        // Flush in WAIT1; response two cycles later is swallowed by DRAIN.
        clear_inputs();
        validIn = 1'b1;
        isMemoryAccessSrc1In = 1'b1;
        memoryAddressSrc1In  = 64'h5000;
        operand1ValIn        = 64'h77;
        memReqReadyIn        = 1'b1;
        step();
        validIn = 1'b0;
        step();
        flushIn = 1'b1;
        step();
        flushIn = 1'b0;
        check("fl.drain_busy", 64'(busyOut), 64'd1);
        check("fl.drain_valid", 64'(validOut), 64'd0);
        step();
        check("fl.drain2_busy", 64'(busyOut), 64'd1);
        check("fl.drain2_valid", 64'(validOut), 64'd0);
        memRespValidIn = 1'b1;
        memRespDataIn  = 64'hBAD;
        step();
        memRespValidIn = 1'b0;
        check_idle("fl.after");
        check("fl.op1_kept", operand1ValOut, 64'h77);

        // Flush in IDLE blocks capture; flush in REQ1 returns to IDLE.
        clear_inputs();
        validIn = 1'b1;
        flushIn = 1'b1;
        operand1ValIn = 64'h1234;
        step();
        check_idle("fl_idle");
        check("fl_idle.op1", operand1ValOut, 64'h77);
        flushIn = 1'b0;
        isMemoryAccessSrc1In = 1'b1;
        step();
        validIn = 1'b0;
        check("fl_req.reqv", 64'(memReqValidOut), 64'd1);
        flushIn = 1'b1;
        step();
        flushIn = 1'b0;
        check_idle("fl_req.after");

        // Asynchronous reset in REQ2.
        clear_inputs();
        validIn = 1'b1;
        isMemoryAccessSrc2In = 1'b1;
        memoryAddressSrc2In  = 64'h6000;
        operand2ValIn        = 64'h99;
        opcodeIn             = 8'h33;
        step();
        validIn = 1'b0;
        check("rst.r2_reqv", 64'(memReqValidOut), 64'd1);
        check("rst.r2_addr", memReqAddrOut, 64'h6000);
        #2;
        reset = 1'b1;
        #1;
        check_idle("rst.mid");
        check("rst.addr", memReqAddrOut, 64'h0);
        check("rst.opc", 64'(opcodeOut), 64'h0);
        check("rst.op2", operand2ValOut, 64'h0);
        step();
        reset = 1'b0;
        memReqReadyIn = 1'b1;
        step();
        check_idle("rst.after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
